// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S audio transmitter.
// Frame geometry, stereo pair layout and underrun counter width.
package i2s_pkg;

    localparam int AUDIO_DW_DEF    = 16;
    localparam int I2S_FRAME_SLOTS = 2 * AUDIO_DW_DEF;
    localparam int UNDERRUN_CNT_W  = 16;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } stereo_pair_t;

endpackage

// File: rtl/i2s_audio_tx_clk_gen.sv
// I2S bit/word clock generator: divider, bck, fall strobe,
// slot counter and lrck. All serial timing derives from fall.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int SLOTS   = I2S_FRAME_SLOTS
) (
    input  logic clk_sys,
    input  logic reset_n,
    output logic bck,
    output logic lrck,
    output logic fall,
    output logic frame
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SLOTS / 2);

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt;
    logic              wrap;

    assign wrap     = (div_cnt == DIV_LAST);
    assign fall     = wrap & bck;
    assign frame    = fall & (slot == SLOT_LAST);
    assign slot_nxt = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);

    // Half-period divider; bck toggles on each wrap for a 50% duty cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Slot counter advances on bck falls; lrck follows the new slot half.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            slot <= SLOT_LAST;
            lrck <= 1'b0;
        end else if (fall) begin
            slot <= slot_nxt;
            lrck <= (slot_nxt >= SLOT_HALF);
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S stereo transmitter with one-pair holding register and underrun repeat.
// Optional macro I2S_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module i2s_audio_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV  = 8,
    parameter int AUDIO_DW = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [AUDIO_DW-1:0] sample_l,
    input  logic [AUDIO_DW-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_bck,
    output logic                i2s_lrck,
    output logic                i2s_data,
    output logic                underrun
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

    localparam int PW = 2 * AUDIO_DW;

    logic [PW-1:0] hold_q;
    logic [PW-1:0] last_q;
    logic [PW-1:0] shift_q;
    logic [PW-1:0] shift_src;
    logic          delay_q;
    logic          fall;
    logic          frame;
    logic          accept;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .SLOTS   (PW)
    ) u_clk_gen (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bck     (i2s_bck),
        .lrck    (i2s_lrck),
        .fall    (fall),
        .frame   (frame)
    );

    assign accept = sample_valid & sample_ready;

    // Frame load picks the held pair, or repeats the last one when empty.
    always_comb begin
        shift_src = shift_q;
        if (frame) begin
            shift_src = sample_ready ? last_q : hold_q;
        end
    end

    // Holding register and ready flag; a load frees it, an accept fills it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_q       <= '0;
            last_q       <= '0;
            sample_ready <= 1'b1;
        end else begin
            if (frame && !sample_ready) begin
                last_q <= hold_q;
            end
            if (accept) begin
                hold_q       <= {sample_l, sample_r};
                sample_ready <= 1'b0;
            end else if (frame && !sample_ready) begin
                sample_ready <= 1'b1;
            end
        end
    end

    // Serial path with one-bck delay so the L MSB trails the lrck edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shift_q  <= '0;
            delay_q  <= 1'b0;
            i2s_data <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame & sample_ready;
            if (fall) begin
                i2s_data <= delay_q;
                delay_q  <= shift_src[PW-1];
                shift_q  <= shift_src << 1;
            end
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    // Saturating count of frames that started without fresh data.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= '0;
        end else if (frame && sample_ready && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
        end
    end
`endif

endmodule
